load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Sits between the core's execute stage and the byte-lane data memory (`mem_addr`, `mem_data_in[0:3]`, `mem_data_out[0:3]`, `mem_write_en`).
- Accepts one load or store request at a time over a valid/ready handshake.
- Performs byte-lane extraction with sign/zero extension for loads.
- Performs read-modify-write for sub-word stores, because the memory has only a word-wide write enable.
- Flags misaligned or illegal accesses without touching memory.

Parameters:
- MEM_LATENCY, 1, cycles from stable `mem_addr` to valid `mem_data_out`; legal range 1..15.

Ports:
- clk  input  1  clock, rising edge.
- rst_b  input  1  reset, asynchronous, active-low.
- req_valid  input  1  request present.
- req_ready  output  1  unit idle and able to accept.
- req_write  input  1  1 = store, 0 = load.
- req_size  input  2  0 = byte, 1 = half, 2 = word, 3 = illegal.
- req_unsigned  input  1  zero-extend loads (LBU/LHU); ignored for word and for stores.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- resp_valid  output  1  one-cycle completion pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_misaligned  output  1  valid with `resp_valid`; access rejected.
- mem_addr  output  32  word-aligned memory address.
- mem_data_out  input  8x[0:3]  memory read bytes; index k = byte at `mem_addr`+k (little-endian).
- mem_data_in  output  8x[0:3]  memory write bytes, same lane order.
- mem_write_en  output  1  memory commits `mem_data_in` at this clock edge.

Behaviour:
- Reset (async assert): state IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_misaligned`=0, `mem_addr`=0, `mem_data_in`=all 0, `mem_write_en`=0, latency counter=0.
- Reset mid-operation aborts the access:
  - no write is issued and no response is produced.
  - `mem_write_en` drops immediately (asynchronously).
- States: IDLE, READ, WRITE, RESP.
- IDLE: `req_ready`=1. Handshake = `req_valid`&&`req_ready` at a rising edge (accept cycle N). Latch size, unsigned, addr, wdata, write.
  - Error if: size=3, or size=1 with addr[0]=1, or size=2 with addr[1:0]!=0. Go to RESP with `resp_misaligned`=1. `mem_addr` is not updated.
  - Load, or store with size 0/1: `mem_addr`<={addr[31:2],2'b00}; go to READ.
  - Store word: `mem_addr`<=aligned addr; `mem_data_in`<=wdata bytes (lane0=wdata[7:0]); go to WRITE.
- READ: `req_ready`=0. Hold `mem_addr` for MEM_LATENCY cycles (counter). In the last READ cycle, sample `mem_data_out` at the edge.
  - Load: compute result; go to RESP.
  - Sub-word store: merge and load `mem_data_in`; go to WRITE.
- Load extraction: lane = addr[1:0].
  - Byte: `mem_data_out[lane]`.
  - Half: {`mem_data_out[lane+1]`,`mem_data_out[lane]`}.
  - Word: all four lanes.
  - Sign-extend bit 7/15 unless unsigned.
- Store merge:
  - Byte: replace lane addr[1:0] with wdata[7:0].
  - Half: replace lanes addr[1:0] and +1 with wdata[7:0], wdata[15:8].
  - Other lanes keep the read value.
- WRITE: `mem_write_en`=1 for exactly one cycle with stable `mem_addr`/`mem_data_in`; go to RESP.
- RESP: `resp_valid`=1 for exactly one cycle, no backpressure; `req_ready`=0; go to IDLE.
  - Response fields hold until the next response.
  - `mem_data_in` is don't-care outside WRITE.
- Latency from accept cycle N (`resp_valid` high in cycle):
  - error: N+1.
  - load: N+MEM_LATENCY+1.
  - word store: N+2.
  - sub-word store: N+MEM_LATENCY+2.
- Throughput: next accept is no earlier than the cycle after RESP. `req_valid` asserted while `req_ready`=0 is ignored and must be held by the producer.
- `mem_write_en` is never asserted for loads or errors. Each store issues exactly one write.

Test Plan:
- Preload word 0x100 bytes {11,82,33,F4}, MEM_LATENCY=1. LB 0x101 -> `resp_rdata`=0xFFFFFF82; LBU 0x101 -> 0x00000082; `resp_valid` at N+2; `mem_addr`=0x100; `mem_write_en` never high.
- LH 0x102 signed -> 0xFFFFF433. LHU 0x102 -> 0x0000F433. LW 0x100 -> 0xF4338211.
- SB 0x103 wdata 0x000000AB -> one `mem_write_en` cycle at N+2 with bytes {11,82,33,AB}; resp at N+3. Readback LW -> 0xAB338211.
- SW 0x104 wdata 0xDEADBEEF -> no read phase; `mem_write_en` at N+1, bytes {EF,BE,AD,DE}; resp at N+2.
- LW 0x102, SH 0x101, size=3 -> `resp_misaligned`=1 at N+1, `resp_rdata`=0, `mem_write_en`=0, `mem_addr` unchanged.
- SH 0x102 with MEM_LATENCY=3; deassert `rst_b` during READ cycle 2 -> `mem_write_en` never asserted, memory unchanged, no `resp_valid`, `req_ready`=1 after release. Back-to-back `req_valid` held high -> second accepted only after first `resp_valid`.

Source files
------------

// File: rtl/load_store_unit.sv
// Load/store unit: byte-lane loads with extension, read-modify-write
// for sub-word stores, and misalignment rejection.
module load_store_unit #(
    parameter int MEM_LATENCY = 1
) (
    input  logic        clk,
    input  logic        rst_b,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic [31:0] mem_addr,
    input  logic [7:0]  mem_data_out [0:3],
    output logic [7:0]  mem_data_in  [0:3],
    output logic        mem_write_en
);

    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    localparam logic [3:0] LAST = 4'(MEM_LATENCY - 1);

    state_t      state;
    logic [3:0]  cnt;
    logic        op_write;
    logic [1:0]  op_size;
    logic        op_unsigned;
    logic [1:0]  op_lane;
    logic [15:0] op_wdata;

    logic        bad_align;
    logic [31:0] load_val;
    logic [7:0]  lo;
    logic [7:0]  hi;
    logic [7:0]  merged [0:3];

    // Classify the incoming request as illegal or misaligned
    always_comb begin
        bad_align = 1'b0;
        unique case (1'b1)
            req_size == 2'd3: bad_align = 1'b1;
            req_size == 2'd2: bad_align = req_addr[1:0] != 2'b00;
            req_size == 2'd1: bad_align = req_addr[0];
            default:          bad_align = 1'b0;
        endcase
    end

    // Pick the addressed lanes out of the read word and extend them
    always_comb begin
        load_val = '0;
        lo = mem_data_out[op_lane];
        hi = mem_data_out[2'(op_lane + 2'd1)];
        unique case (op_size)
            2'd0: load_val = op_unsigned ? {24'd0, lo}
                                         : {{24{lo[7]}}, lo};
            2'd1: load_val = op_unsigned ? {16'd0, hi, lo}
                                         : {{16{hi[7]}}, hi, lo};
            default: load_val = {mem_data_out[3], mem_data_out[2],
                                 mem_data_out[1], mem_data_out[0]};
        endcase
    end

    // Overlay store bytes onto the read word; untouched lanes pass through
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            merged[k] = mem_data_out[k];
            if (2'(k) == op_lane)
                merged[k] = op_wdata[7:0];
            if (op_size == 2'd1 && 2'(k) == 2'(op_lane + 2'd1))
                merged[k] = op_wdata[15:8];
        end
    end

    // Request sequencing with all outputs registered
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state           <= IDLE;
            cnt             <= '0;
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            resp_misaligned <= 1'b0;
            mem_addr        <= '0;
            mem_write_en    <= 1'b0;
            op_write        <= 1'b0;
            op_size         <= '0;
            op_unsigned     <= 1'b0;
            op_lane         <= '0;
            op_wdata        <= '0;
            for (int k = 0; k < 4; k++)
                mem_data_in[k] <= '0;
        end else begin
            resp_valid   <= 1'b0;
            mem_write_en <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (req_valid) begin
                        req_ready   <= 1'b0;
                        op_write    <= req_write;
                        op_size     <= req_size;
                        op_unsigned <= req_unsigned;
                        op_lane     <= req_addr[1:0];
                        op_wdata    <= req_wdata[15:0];
                        cnt         <= '0;
                        if (bad_align) begin
                            resp_valid      <= 1'b1;
                            resp_rdata      <= '0;
                            resp_misaligned <= 1'b1;
                            state           <= RESP;
                        end else if (req_write && req_size == 2'd2) begin
                            mem_addr       <= {req_addr[31:2], 2'b00};
                            mem_data_in[0] <= req_wdata[7:0];
                            mem_data_in[1] <= req_wdata[15:8];
                            mem_data_in[2] <= req_wdata[23:16];
                            mem_data_in[3] <= req_wdata[31:24];
                            mem_write_en   <= 1'b1;
                            state          <= WRITE;
                        end else begin
                            mem_addr <= {req_addr[31:2], 2'b00};
                            state    <= READ;
                        end
                    end
                end
                READ: begin
                    if (cnt == LAST) begin
                        cnt <= '0;
                        if (op_write) begin
                            for (int k = 0; k < 4; k++)
                                mem_data_in[k] <= merged[k];
                            mem_write_en <= 1'b1;
                            state        <= WRITE;
                        end else begin
                            resp_valid      <= 1'b1;
                            resp_rdata      <= load_val;
                            resp_misaligned <= 1'b0;
                            state           <= RESP;
                        end
                    end else begin
                        cnt <= cnt + 4'd1;
                    end
                end
                WRITE: begin
                    resp_valid      <= 1'b1;
                    resp_rdata      <= '0;
                    resp_misaligned <= 1'b0;
                    state           <= RESP;
                end
                RESP: begin
                    req_ready <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: two instances (latency 1 and 3) driven by
// directed and random requests against a byte-array reference model.
module tb_load_store_unit;

    typedef struct packed {
        logic        write;
        logic [1:0]  size;
        logic        uns;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]       rst_b;
    logic [1:0]       req_valid;
    logic [1:0]       req_ready;
    logic [1:0]       req_write;
    logic [1:0][1:0]  req_size;
    logic [1:0]       req_unsigned;
    logic [1:0][31:0] req_addr;
    logic [1:0][31:0] req_wdata;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] resp_rdata;
    logic [1:0]       resp_misaligned;
    logic [1:0][31:0] mem_addr;
    logic [1:0]       mem_write_en;
    logic [7:0] mdo0 [0:3];
    logic [7:0] mdo1 [0:3];
    logic [7:0] mdi0 [0:3];
    logic [7:0] mdi1 [0:3];

    logic [7:0] dmem  [2][512];
    logic [7:0] ref_b [2][512];
    bit   [31:0] prev_addr [2];
    int   age [2];
    int   an [2];
    int   wcount [2];
    int   rcount [2];
    logic load_mem;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] last_rdata;

    load_store_unit #(.MEM_LATENCY(1)) u0 (
        .clk(clk), .rst_b(rst_b[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .req_addr(req_addr[0]),
        .req_wdata(req_wdata[0]), .resp_valid(resp_valid[0]),
        .resp_rdata(resp_rdata[0]),
        .resp_misaligned(resp_misaligned[0]),
        .mem_addr(mem_addr[0]), .mem_data_out(mdo0),
        .mem_data_in(mdi0), .mem_write_en(mem_write_en[0])
    );

    load_store_unit #(.MEM_LATENCY(3)) u1 (
        .clk(clk), .rst_b(rst_b[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .req_addr(req_addr[1]),
        .req_wdata(req_wdata[1]), .resp_valid(resp_valid[1]),
        .resp_rdata(resp_rdata[1]),
        .resp_misaligned(resp_misaligned[1]),
        .mem_addr(mem_addr[1]), .mem_data_out(mdo1),
        .mem_data_in(mdi1), .mem_write_en(mem_write_en[1])
    );

    function automatic logic [7:0] mdi(input int i, input int k);
        return (i == 0) ? mdi0[k] : mdi1[k];
    endfunction

    // Memory read data is garbage until the address has been stable long enough
    always_comb begin
        for (int g = 0; g < 2; g++)
            an[g] = (mem_addr[g] == prev_addr[g]) ? age[g] + 1 : 1;
        for (int k = 0; k < 4; k++) begin
            mdo0[k] = (an[0] >= 1) ? dmem[0][{mem_addr[0][8:2], 2'(k)}] : 8'hA5;
            mdo1[k] = (an[1] >= 3) ? dmem[1][{mem_addr[1][8:2], 2'(k)}] : 8'hA5;
        end
    end

    // Memory write port, address-age tracking and event counters
    always @(posedge clk) begin
        for (int g = 0; g < 2; g++) begin
            prev_addr[g] <= mem_addr[g];
            age[g] <= an[g];
            if (resp_valid[g]) rcount[g] <= rcount[g] + 1;
            if (mem_write_en[g]) begin
                wcount[g] <= wcount[g] + 1;
                for (int k = 0; k < 4; k++)
                    dmem[g][{mem_addr[g][8:2], 2'(k)}] <= mdi(g, k);
            end
            if (load_mem)
                for (int j = 0; j < 512; j++) dmem[g][j] <= ref_b[g][j];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic req_t mk(input logic w, input logic [1:0] s,
                                input logic u, input logic [31:0] a,
                                input logic [31:0] d);
        req_t r;
        r.write = w; r.size = s; r.uns = u; r.addr = a; r.wdata = d;
        return r;
    endfunction

    function automatic logic [31:0] dword(input int i, input int b);
        return {dmem[i][b+3], dmem[i][b+2], dmem[i][b+1], dmem[i][b]};
    endfunction

    function automatic logic [31:0] rword(input int i, input int b);
        return {ref_b[i][b+3], ref_b[i][b+2], ref_b[i][b+1], ref_b[i][b]};
    endfunction

    // Reference: byte-addressed memory, latency from the timing rules
    task automatic model(input int i, input req_t r,
                         output logic [31:0] rd, output logic mis,
                         output int lat, output int wcyc);
        int L, a, lane, wb;
        logic [31:0] word, sh;
        L = (i == 0) ? 1 : 3;
        a = int'(r.addr[8:0]);
        lane = a % 4;
        wb = a - lane;
        mis = (r.size == 2'd3) || (r.size == 2'd1 && a % 2 == 1)
           || (r.size == 2'd2 && lane != 0);
        rd = '0;
        wcyc = 0;
        if (mis) begin
            lat = 1;
        end else if (!r.write) begin
            word = rword(i, wb);
            sh = word >> (8 * lane);
            case (r.size)
                2'd0: rd = r.uns ? {24'd0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
                2'd1: rd = r.uns ? {16'd0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
                default: rd = word;
            endcase
            lat = L + 1;
        end else begin
            for (int j = 0; j < (1 << r.size); j++)
                ref_b[i][a+j] = r.wdata[8*j +: 8];
            lat  = (r.size == 2'd2) ? 2 : L + 2;
            wcyc = (r.size == 2'd2) ? 1 : L + 1;
        end
    endtask

    task automatic drive(input int i, input req_t r, input logic v);
        req_write[i] = r.write;
        req_size[i] = r.size;
        req_unsigned[i] = r.uns;
        req_addr[i] = r.addr;
        req_wdata[i] = r.wdata;
        req_valid[i] = v;
    endtask

    // Entered at the falling edge of cycle N+1 after the accept edge
    task automatic wait_resp(input int i, input req_t r,
                             input logic [31:0] erd, input logic emis,
                             input int elat, input int ewc,
                             input logic [31:0] ab);
        int w0, c, got, wat, busy, wb;
        logic [31:0] ea;
        w0 = wcount[i];
        c = 1; got = 0; wat = 0; busy = 0;
        wb = int'(r.addr[8:2]) * 4;
        ea = {r.addr[31:2], 2'b00};
        while (got == 0 && c <= 40) begin
            if (mem_write_en[i]) begin
                if (wat == 0) wat = c;
                chk("wr_addr", mem_addr[i], ea);
                for (int k = 0; k < 4; k++)
                    chk("wr_lane", 32'(mdi(i, k)), 32'(ref_b[i][wb+k]));
            end
            if (resp_valid[i]) begin
                got = c;
            end else begin
                if (req_ready[i]) busy++;
                @(negedge clk);
                c++;
            end
        end
        chk("latency", got, elat);
        chk("write_cycle", wat, ewc);
        chk("rdata", resp_rdata[i], erd);
        chk("misaligned", 32'(resp_misaligned[i]), 32'(emis));
        chk("write_count", wcount[i] - w0,
            (r.write && !emis) ? 1 : 0);
        chk("busy_ready", busy, 0);
        if (emis) chk("err_addr_hold", mem_addr[i], ab);
        last_rdata = resp_rdata[i];
        @(negedge clk);
        chk("resp_pulse", 32'(resp_valid[i]), 0);
        chk("ready_after", 32'(req_ready[i]), 1);
        chk("mem_word", dword(i, wb), rword(i, wb));
    endtask

    task automatic wait_ready(input int i);
        int k;
        k = 0;
        while (!req_ready[i] && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("idle_ready", 32'(req_ready[i]), 1);
    endtask

    task automatic do_req(input int i, input req_t r);
        logic [31:0] erd, ab;
        logic emis;
        int elat, ewc;
        wait_ready(i);
        ab = mem_addr[i];
        model(i, r, erd, emis, elat, ewc);
        drive(i, r, 1'b1);
        @(negedge clk);
        req_valid[i] = 1'b0;
        wait_resp(i, r, erd, emis, elat, ewc, ab);
    endtask

    function automatic req_t rand_req();
        logic [31:0] a;
        a = ($urandom() & 32'hFFFF_FE00) | 32'($urandom_range(0, 511));
        return mk(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), a, $urandom());
    endfunction

    initial begin
        req_t a, b, s;
        logic [31:0] erd_a, erd_b, snap;
        logic emis_a, emis_b;
        int lat_a, lat_b, wc_a, wc_b, w0, r0;

        rst_b = '0;
        req_valid = '0;
        req_write = '0;
        req_size = '0;
        req_unsigned = '0;
        req_addr = '0;
        req_wdata = '0;
        for (int g = 0; g < 2; g++) begin
            for (int j = 0; j < 512; j++) ref_b[g][j] = 8'($urandom());
            ref_b[g][256] = 8'h11;
            ref_b[g][257] = 8'h82;
            ref_b[g][258] = 8'h33;
            ref_b[g][259] = 8'hF4;
        end
        load_mem = 1'b1;
        @(negedge clk);
        load_mem = 1'b0;

        for (int g = 0; g < 2; g++) begin
            chk("rst_ready", 32'(req_ready[g]), 1);
            chk("rst_resp_valid", 32'(resp_valid[g]), 0);
            chk("rst_rdata", resp_rdata[g], 0);
            chk("rst_misaligned", 32'(resp_misaligned[g]), 0);
            chk("rst_mem_addr", mem_addr[g], 0);
            chk("rst_write_en", 32'(mem_write_en[g]), 0);
            for (int k = 0; k < 4; k++)
                chk("rst_data_in", 32'(mdi(g, k)), 0);
        end
        @(negedge clk);
        rst_b = '1;
        @(negedge clk);

        do_req(0, mk(0, 2'd0, 0, 32'h101, 0));
        chk("lb_101", last_rdata, 32'hFFFF_FF82);
        chk("lb_mem_addr", mem_addr[0], 32'h100);
        do_req(0, mk(0, 2'd0, 1, 32'h101, 0));
        chk("lbu_101", last_rdata, 32'h0000_0082);
        do_req(0, mk(0, 2'd1, 0, 32'h102, 0));
        chk("lh_102", last_rdata, 32'hFFFF_F433);
        do_req(0, mk(0, 2'd1, 1, 32'h102, 0));
        chk("lhu_102", last_rdata, 32'h0000_F433);
        do_req(0, mk(0, 2'd2, 0, 32'h100, 0));
        chk("lw_100", last_rdata, 32'hF433_8211);
        do_req(0, mk(1, 2'd0, 0, 32'h103, 32'h0000_00AB));
        do_req(0, mk(0, 2'd2, 0, 32'h100, 0));
        chk("lw_after_sb", last_rdata, 32'hAB33_8211);
        do_req(0, mk(1, 2'd2, 0, 32'h104, 32'hDEAD_BEEF));
        chk("sw_mem", dword(0, 260), 32'hDEAD_BEEF);
        do_req(0, mk(0, 2'd2, 0, 32'h102, 0));
        do_req(0, mk(1, 2'd1, 0, 32'h101, 32'h1234));
        do_req(0, mk(0, 2'd3, 0, 32'h100, 0));
        do_req(0, mk(1, 2'd3, 0, 32'h104, 32'h55));
        do_req(1, mk(0, 2'd1, 0, 32'h102, 0));
        chk("l3_lh_102", last_rdata, 32'hFFFF_F433);
        do_req(1, mk(1, 2'd0, 0, 32'h101, 32'h0000_007E));

        for (int n = 0; n < 150; n++)
            for (int i = 0; i < 2; i++)
                do_req(i, rand_req());

        // Back-to-back: second request held valid while the first runs
        a = mk(0, 2'd2, 0, 32'h100, 0);
        b = mk(0, 2'd0, 1, 32'h103, 0);
        wait_ready(0);
        model(0, a, erd_a, emis_a, lat_a, wc_a);
        drive(0, a, 1'b1);
        @(negedge clk);
        model(0, b, erd_b, emis_b, lat_b, wc_b);
        drive(0, b, 1'b1);
        wait_resp(0, a, erd_a, emis_a, lat_a, wc_a, mem_addr[0]);
        @(negedge clk);
        req_valid[0] = 1'b0;
        wait_resp(0, b, erd_b, emis_b, lat_b, wc_b, mem_addr[0]);

        // Reset in the middle of a sub-word store's read phase
        s = mk(1, 2'd1, 0, 32'h102, 32'h0000_5A5A);
        wait_ready(1);
        snap = dword(1, 256);
        w0 = wcount[1];
        r0 = rcount[1];
        drive(1, s, 1'b1);
        @(negedge clk);
        req_valid[1] = 1'b0;
        @(negedge clk);
        rst_b[1] = 1'b0;
        #1;
        chk("abort_write_en", 32'(mem_write_en[1]), 0);
        chk("abort_ready", 32'(req_ready[1]), 1);
        chk("abort_resp", 32'(resp_valid[1]), 0);
        chk("abort_mem_addr", mem_addr[1], 0);
        repeat (2) @(negedge clk);
        rst_b[1] = 1'b1;
        repeat (6) @(negedge clk);
        chk("abort_no_write", wcount[1] - w0, 0);
        chk("abort_no_resp", rcount[1] - r0, 0);
        chk("abort_mem", dword(1, 256), snap);
        chk("abort_ready_after", 32'(req_ready[1]), 1);
        do_req(1, s);
        do_req(1, mk(0, 2'd2, 0, 32'h100, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
